qupls4_fu_credit_tracker: RTL
=============================

// Module: qupls4_fu_credit_tracker
// PURPOSE
// - Tracks reservation-station (RS) occupancy for each functional unit (FU).
// - Drives the busy[15:0] vector the instruction dispatcher samples before it
//   assigns an op to a unit.
// - Counts ops dispatched into each FU's RS and ops released (issued) from it.
// - Asserts busy early enough that the registered dispatcher can never overfill an RS.
// - Sits between the dispatcher outputs and the per-FU reservation stations.
// PARAMETERS
// - NFU       16  number of FU slots; index 15 (FU_NONE) means "no unit".
// - NLANE     4   dispatch lanes per cycle.
// - RS_DEPTH  4   entries per FU reservation station.
// - HEADROOM  1   slots held back to cover the one-cycle dispatch pipeline.
// PORTS
// - clk            in   1          clock, all state on rising edge
// - rst            in   1          asynchronous reset, active-low
// - flush          in   1          pipeline flush; all RS contents discarded
// - disp_v         in   NLANE      lane valid (dispatcher rob_dispatched_v)
// - disp_fu        in   NLANE*4    lane FU index (rse_o[k].funcunit)
// - rel            in   NFU        per-FU release pulse: one RS entry issued
// - fu_disable     in   NFU        config mask; forces busy for that unit
// - busy           out  NFU        to dispatcher: do not send to this FU
// - cnt            out  NFU*3      per-FU occupancy, debug/perf
// - err_ovf        out  1          sticky: dispatch into a full RS
// - err_unf        out  1          sticky: release from an empty RS
// BEHAVIOUR
// - Reset (rst=0, async): all counters 0, busy = NFU'b0 (then masked by
//   fu_disable combinationally), err_ovf = 0, err_unf = 0.
// - Per FU f, each cycle: inc = number of lanes k with disp_v[k] &&
//   disp_fu[k]==f && f!=FU_NONE (range 0..NLANE); dec = rel[f].
// - Update: cnt_next = cnt + inc - dec, computed in width clog2(RS_DEPTH+NLANE)+1.
//   - Same-cycle dispatch and release both apply; the net change is used.
//   - Result > RS_DEPTH: saturate to RS_DEPTH and set err_ovf.
//   - Result < 0 (release when empty and inc=0): hold 0 and set err_unf.
// - busy[f] is registered from cnt_next:
//   busy[f] = (cnt_next + HEADROOM >= RS_DEPTH) | fu_disable[f].
//   - Latency: a dispatch in cycle N is reflected in busy at cycle N+1.
//   - A release in cycle N clears busy at N+1 if the threshold is no longer met.
// - busy[FU_NONE] is always 0 and its counter is never written; lanes with
//   disp_fu==15 are ignored even when disp_v=1.
// - flush (synchronous): counters go to 0 and busy to fu_disable next cycle.
//   - Flush overrides dispatch and release in the same cycle.
//   - err flags are not cleared by flush.
// - err_ovf and err_unf are sticky until reset.
// - fu_disable is applied combinationally on the busy output (0-cycle effect).
//   - Counters keep tracking while a unit is disabled, so in-flight ops still
//     drain correctly.
// - Reset mid-stream: all state clears immediately; no pending update survives.
// STRUCTURE
// - Qupls4_pkg holds: NFU, FU_NONE=4'd15, RS_DEPTH, and the FU index constants
//   (SAU0=0, SAU1=1, MUL=2, DIV=3, FMA0=4, TRIG=6, FCU=7, AGEN0=8, FPU=12).
// - Sub-module qupls4_fu_credit_counter: one counter, with the inc/dec/saturate/
//   flush logic and the per-unit ovf/unf pulses. Instantiated NFU-1 times by a
//   generate loop.
// - Top level: lane-to-FU match decode (popcount per FU), OR-reduction of the
//   error pulses into the sticky flags, and the busy masking.
// TESTING
// - Reset: hold rst=0 with fu_disable=0 -> busy=0, cnt all 0, err flags 0;
//   rst=1 with no traffic -> state unchanged.
// - Fill FU 2: dispatch to FU2 on lane0 for 3 cycles, no rel ->
//   cnt[2] = 1, 2, 3; busy[2] rises the cycle after the 3rd dispatch
//   (3 + 1 >= 4); err_ovf stays 0.
// - Simultaneous events: with cnt[7]=3, in the same cycle dispatch FU7 and
//   assert rel[7] -> cnt[7] stays 3 and busy[7] stays 1.
// - Multi-lane: lanes 0-3 all target FU0 with cnt[0]=2 -> cnt[0]=4 (saturated)
//   and err_ovf=1 next cycle.
// - Underflow and ignored lane: rel[12] with cnt[12]=0 -> cnt[12]=0 and
//   err_unf=1; disp_fu=15 with disp_v=1 -> no counter changes.
// - Flush and disable: cnt[4]=2 and fu_disable[4]=1, then flush together with
//   a dispatch to FU4 -> cnt[4]=0 and busy[4]=1 (disabled).
//   - Then clear fu_disable -> busy[4]=0 in the same cycle.

Source files
------------

// File: rtl/qupls4_fu_credit_tracker_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// qupls4_fu_credit_tracker_pkg : FU indices and RS credit-tracking constants
// Rev 1.0
// ----------------------------------------------------------------------------
package qupls4_fu_credit_tracker_pkg;

  localparam int NFU      = 16;
  localparam int NLANE    = 4;
  localparam int RS_DEPTH = 4;
  localparam int HEADROOM = 1;

  localparam int FU_W  = 4;
  localparam int CNT_W = $clog2(RS_DEPTH + 1);
  localparam int INC_W = $clog2(NLANE + 1);
  localparam int SUM_W = $clog2(RS_DEPTH + NLANE) + 1;

  typedef logic [FU_W-1:0] fu_idx_t;

  localparam fu_idx_t FU_NONE = 4'd15;
  localparam fu_idx_t SAU0    = 4'd0;
  localparam fu_idx_t SAU1    = 4'd1;
  localparam fu_idx_t MUL     = 4'd2;
  localparam fu_idx_t DIV     = 4'd3;
  localparam fu_idx_t FMA0    = 4'd4;
  localparam fu_idx_t TRIG    = 4'd6;
  localparam fu_idx_t FCU     = 4'd7;
  localparam fu_idx_t AGEN0   = 4'd8;
  localparam fu_idx_t FPU     = 4'd12;

endpackage
`default_nettype wire

// File: rtl/qupls4_fu_credit_tracker_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// qupls4_fu_credit_counter : one RS occupancy counter with saturation/flush
// Rev 1.0
// ----------------------------------------------------------------------------
module qupls4_fu_credit_counter
  import qupls4_fu_credit_tracker_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [INC_W-1:0] inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             ovf,
  output logic             unf
);

  logic [SUM_W-1:0] raw;
  logic [SUM_W-1:0] nxt;

  // raw is cnt+inc; an empty result with a release pending is the only underflow case
  always_comb begin
    raw = SUM_W'(cnt) + SUM_W'(inc);
    nxt = raw;
    ovf = 1'b0;
    unf = 1'b0;
    if (flush) begin
      nxt = '0;
    end else if (dec && raw == '0) begin
      unf = 1'b1;
    end else begin
      nxt = raw - SUM_W'(dec);
      if (nxt > SUM_W'(RS_DEPTH)) begin
        nxt = SUM_W'(RS_DEPTH);
        ovf = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else begin
      cnt  <= nxt[CNT_W-1:0];
      busy <= (nxt + SUM_W'(HEADROOM)) >= SUM_W'(RS_DEPTH);
    end
  end

endmodule
`default_nettype wire

// File: rtl/qupls4_fu_credit_tracker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// qupls4_fu_credit_tracker : per-FU RS occupancy and dispatcher busy vector
// Rev 1.0
// ----------------------------------------------------------------------------
module qupls4_fu_credit_tracker
  import qupls4_fu_credit_tracker_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [NLANE-1:0]      disp_v,
  input  logic [NLANE*FU_W-1:0] disp_fu,
  input  logic [NFU-1:0]        rel,
  input  logic [NFU-1:0]        fu_disable,
  output logic [NFU-1:0]        busy,
  output logic [NFU*CNT_W-1:0]  cnt,
  output logic                  err_ovf,
  output logic                  err_unf
);

  logic [INC_W-1:0] inc [NFU-1];
  logic [NFU-2:0]   busy_q;
  logic [NFU-2:0]   ovf_p;
  logic [NFU-2:0]   unf_p;
  logic             unused_fu_none;

  // FU_NONE is never tracked, so its disable bit has no effect
  assign unused_fu_none = fu_disable[NFU-1];

  always_comb begin
    for (int f = 0; f < NFU - 1; f++) begin
      inc[f] = '0;
      for (int k = 0; k < NLANE; k++) begin
        if (disp_v[k] && disp_fu[k*FU_W +: FU_W] == FU_W'(f))
          inc[f] = inc[f] + INC_W'(1);
      end
    end
  end

  generate
    for (genvar f = 0; f < NFU - 1; f++) begin : g_fu
      qupls4_fu_credit_counter u_cnt (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .inc   (inc[f]),
        .dec   (rel[f]),
        .cnt   (cnt[f*CNT_W +: CNT_W]),
        .busy  (busy_q[f]),
        .ovf   (ovf_p[f]),
        .unf   (unf_p[f])
      );
    end
  endgenerate

  assign cnt[NFU*CNT_W-1 -: CNT_W] = '0;
  assign busy = {1'b0, busy_q | fu_disable[NFU-2:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      err_ovf <= err_ovf | (|ovf_p);
      err_unf <= err_unf | (|unf_p);
    end
  end

endmodule
`default_nettype wire
